// File: rtl/imem_fetch_if.sv
// Fetch controller bus: instruction memory port, redirect input and decode handshake.
// The master side is the fetch controller; the slave side is memory/decode/branch logic.
interface imem_fetch_if;
    logic        fetch_en;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_o;
    logic [63:0] inst_pc;
    logic        misaligned_o;

    modport master (
        input  fetch_en, imem_data, redirect_valid, redirect_pc, inst_ready,
        output imem_addr, inst_valid, inst_o, inst_pc, misaligned_o
    );

    modport slave (
        output fetch_en, imem_data, redirect_valid, redirect_pc, inst_ready,
        input  imem_addr, inst_valid, inst_o, inst_pc, misaligned_o
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational instruction
// memory into a small {pc, inst} FIFO and hands entries to decode over valid/ready.
//
//   state | meaning
//   IDLE  | fetching disabled; FIFO may still drain
//   FETCH | one push per cycle while fetch_en is high and the FIFO has room
//   HALT  | misaligned redirect seen; frozen until reset
module imem_fetch_ctrl #(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int          FIFO_DEPTH_POW = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    imem_fetch_if.master bus
);
    localparam int DEPTH = 1 << FIFO_DEPTH_POW;

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t state, state_nxt;

    logic [63:0]             pc;
    logic                    misaligned_q;
    logic [63:0]             fifo_pc   [DEPTH];
    logic [31:0]             fifo_inst [DEPTH];
    logic [FIFO_DEPTH_POW:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_POW-1:0] wr_idx, rd_idx;
    logic                    empty, full;
    logic                    push, pop, redirect, redirect_bad;

    assign wr_idx = wr_ptr[FIFO_DEPTH_POW-1:0];
    assign rd_idx = rd_ptr[FIFO_DEPTH_POW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[FIFO_DEPTH_POW] != rd_ptr[FIFO_DEPTH_POW]) && (wr_idx == rd_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (redirect_bad)
                    state_nxt = HALT;
                else if (!redirect && bus.fetch_en)
                    state_nxt = FETCH;
            end
            FETCH: begin
                if (redirect_bad)
                    state_nxt = HALT;
                else if (!redirect && !bus.fetch_en)
                    state_nxt = IDLE;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // Redirects are ignored once halted so imem_addr keeps the offending PC.
    always_comb begin
        redirect     = 1'b0;
        redirect_bad = 1'b0;
        push         = 1'b0;
        pop          = !empty && bus.inst_ready;
        if (state != HALT) begin
            redirect     = bus.redirect_valid;
            redirect_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
        end
        if ((state == FETCH) && bus.fetch_en && !redirect && (!full || pop))
            push = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            misaligned_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= '0;
            end
        end else if (redirect) begin
            pc     <= bus.redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            if (redirect_bad)
                misaligned_q <= 1'b1;
        end else begin
            if (push) begin
                fifo_pc[wr_idx]   <= pc;
                fifo_inst[wr_idx] <= bus.imem_data;
                wr_ptr            <= wr_ptr + 1'b1;
                pc                <= pc + 64'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign bus.imem_addr    = pc;
    assign bus.inst_valid   = !empty;
    assign bus.inst_o       = fifo_inst[rd_idx];
    assign bus.inst_pc      = fifo_pc[rd_idx];
    assign bus.misaligned_o = misaligned_q;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: expected PCs are queued per scenario and popped on each
// decode transfer; instruction words come from a bench-side memory function.
module tb_imem_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   passed = 0;
    logic [63:0] sbq[$];
    logic [63:0] exp_pc;

    imem_fetch_if bus();

    imem_fetch_ctrl #(.RESET_PC(64'h0), .FIFO_DEPTH_POW(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h0000_0013;
            64'h4:   return 32'h0010_0093;
            64'h8:   return 32'h0020_0113;
            64'hC:   return 32'h0030_0193;
            default: return a[33:2] ^ 32'h5EED_0000;
        endcase
    endfunction

    assign bus.imem_data = memf(bus.imem_addr);

    task automatic apply_reset();
        rst_n              = 1'b0;
        bus.fetch_en       = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.fetch_en       = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.imem_addr !== 64'h0) $display("FAIL reset_pc got=%h exp=0", bus.imem_addr);
        else passed++;
        checks++;
        if (bus.inst_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.inst_valid);
        else passed++;
        checks++;
        if (bus.inst_o !== 32'h0) $display("FAIL reset_inst got=%h exp=0", bus.inst_o);
        else passed++;
        checks++;
        if (bus.inst_pc !== 64'h0) $display("FAIL reset_inst_pc got=%h exp=0", bus.inst_pc);
        else passed++;
        checks++;
        if (bus.misaligned_o !== 1'b0) $display("FAIL reset_misaligned got=%b exp=0", bus.misaligned_o);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        int first = -1;
        int last  = -1;
        apply_reset();
        bus.fetch_en   = 1'b1;
        bus.inst_ready = 1'b1;
        sbq.push_back(64'h0); sbq.push_back(64'h4); sbq.push_back(64'h8); sbq.push_back(64'hC);
        for (int c = 0; c < 40 && sbq.size() > 0; c++) begin
            if (bus.inst_valid && first < 0) first = c;
            if (bus.inst_valid && bus.inst_ready) begin
                exp_pc = sbq.pop_front();
                last   = c;
                checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_o !== memf(exp_pc))
                    $display("FAIL stream_head pc=%h inst=%h exp pc=%h inst=%h",
                             bus.inst_pc, bus.inst_o, exp_pc, memf(exp_pc));
                else passed++;
            end
            @(negedge clk);
        end
        checks++;
        if (first != 2) $display("FAIL stream_latency got=%0d exp=2", first);
        else passed++;
        checks++;
        if (last != 5) $display("FAIL stream_rate last=%0d exp=5", last);
        else passed++;
        checks++;
        if (sbq.size() != 0) $display("FAIL stream_timeout left=%0d exp=0", sbq.size());
        else passed++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.fetch_en   = 1'b1;
        bus.inst_ready = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.imem_addr !== 64'h8) $display("FAIL bp_addr got=%h exp=8", bus.imem_addr);
        else passed++;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h0)
            $display("FAIL bp_head valid=%b pc=%h exp valid=1 pc=0", bus.inst_valid, bus.inst_pc);
        else passed++;
        bus.inst_ready = 1'b1;
        sbq.push_back(64'h0); sbq.push_back(64'h4); sbq.push_back(64'h8);
        for (int c = 0; c < 40 && sbq.size() > 0; c++) begin
            if (bus.inst_valid && bus.inst_ready) begin
                exp_pc = sbq.pop_front();
                checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_o !== memf(exp_pc))
                    $display("FAIL bp_head pc=%h inst=%h exp pc=%h inst=%h",
                             bus.inst_pc, bus.inst_o, exp_pc, memf(exp_pc));
                else passed++;
            end
            @(negedge clk);
        end
        checks++;
        if (sbq.size() != 0) $display("FAIL bp_timeout left=%0d exp=0", sbq.size());
        else passed++;
    endtask

    task automatic test_redirect();
        apply_reset();
        bus.fetch_en   = 1'b1;
        bus.inst_ready = 1'b0;
        repeat (6) @(negedge clk);
        bus.inst_ready = 1'b1;
        sbq.push_back(64'h0); sbq.push_back(64'h4); sbq.push_back(64'h8);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 64'h40;
            end
            if (bus.inst_valid && bus.inst_ready && sbq.size() > 0) begin
                exp_pc = sbq.pop_front();
                checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_o !== memf(exp_pc))
                    $display("FAIL redir_pre pc=%h inst=%h exp pc=%h inst=%h",
                             bus.inst_pc, bus.inst_o, exp_pc, memf(exp_pc));
                else passed++;
            end
            @(negedge clk);
        end
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 64'h40)
            $display("FAIL redir_flush valid=%b addr=%h exp valid=0 addr=40", bus.inst_valid, bus.imem_addr);
        else passed++;
        checks++;
        if (sbq.size() != 0) $display("FAIL redir_pre_left left=%0d exp=0", sbq.size());
        else passed++;
        sbq.delete();
        sbq.push_back(64'h40); sbq.push_back(64'h44);
        for (int c = 0; c < 40 && sbq.size() > 0; c++) begin
            if (bus.inst_valid && bus.inst_ready) begin
                exp_pc = sbq.pop_front();
                checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_o !== memf(exp_pc))
                    $display("FAIL redir_post pc=%h inst=%h exp pc=%h inst=%h",
                             bus.inst_pc, bus.inst_o, exp_pc, memf(exp_pc));
                else passed++;
            end
            @(negedge clk);
        end
        checks++;
        if (sbq.size() != 0) $display("FAIL redir_timeout left=%0d exp=0", sbq.size());
        else passed++;
    endtask

    task automatic test_misaligned();
        apply_reset();
        bus.fetch_en   = 1'b1;
        bus.inst_ready = 1'b0;
        repeat (4) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h42;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b1;
        checks++;
        if (bus.misaligned_o !== 1'b1) $display("FAIL mis_flag got=%b exp=1", bus.misaligned_o);
        else passed++;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 64'h42)
                $display("FAIL mis_halt cyc=%0d valid=%b addr=%h exp valid=0 addr=42",
                         c, bus.inst_valid, bus.imem_addr);
            else passed++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.misaligned_o !== 1'b0 || bus.imem_addr !== 64'h0)
            $display("FAIL mis_reset flag=%b addr=%h exp flag=0 addr=0", bus.misaligned_o, bus.imem_addr);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_drop();
        apply_reset();
        bus.fetch_en   = 1'b1;
        bus.inst_ready = 1'b0;
        repeat (6) @(negedge clk);
        bus.fetch_en   = 1'b0;
        bus.inst_ready = 1'b1;
        sbq.push_back(64'h0); sbq.push_back(64'h4);
        for (int c = 0; c < 40 && sbq.size() > 0; c++) begin
            if (bus.inst_valid && bus.inst_ready) begin
                exp_pc = sbq.pop_front();
                checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_o !== memf(exp_pc))
                    $display("FAIL drop_drain pc=%h inst=%h exp pc=%h inst=%h",
                             bus.inst_pc, bus.inst_o, exp_pc, memf(exp_pc));
                else passed++;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 64'h8)
            $display("FAIL drop_hold valid=%b addr=%h exp valid=0 addr=8", bus.inst_valid, bus.imem_addr);
        else passed++;
        bus.fetch_en = 1'b1;
        sbq.push_back(64'h8); sbq.push_back(64'hC);
        for (int c = 0; c < 40 && sbq.size() > 0; c++) begin
            if (bus.inst_valid && bus.inst_ready) begin
                exp_pc = sbq.pop_front();
                checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_o !== memf(exp_pc))
                    $display("FAIL drop_resume pc=%h inst=%h exp pc=%h inst=%h",
                             bus.inst_pc, bus.inst_o, exp_pc, memf(exp_pc));
                else passed++;
            end
            @(negedge clk);
        end
        checks++;
        if (sbq.size() != 0) $display("FAIL drop_timeout left=%0d exp=0", sbq.size());
        else passed++;
    endtask

    task automatic test_wrap();
        apply_reset();
        bus.fetch_en   = 1'b1;
        bus.inst_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b1;
        sbq.push_back(64'hFFFF_FFFF_FFFF_FFF8); sbq.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        sbq.push_back(64'h0);                   sbq.push_back(64'h4);
        for (int c = 0; c < 40 && sbq.size() > 0; c++) begin
            if (bus.inst_valid && bus.inst_ready) begin
                exp_pc = sbq.pop_front();
                checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_o !== memf(exp_pc))
                    $display("FAIL wrap_head pc=%h inst=%h exp pc=%h inst=%h",
                             bus.inst_pc, bus.inst_o, exp_pc, memf(exp_pc));
                else passed++;
            end
            @(negedge clk);
        end
        checks++;
        if (sbq.size() != 0) $display("FAIL wrap_timeout left=%0d exp=0", sbq.size());
        else passed++;
        checks++;
        if (bus.misaligned_o !== 1'b0) $display("FAIL wrap_flag got=%b exp=0", bus.misaligned_o);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_fetch_drop();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
